apb_rr_master_arbiter: RTL and testbench
========================================

// Module: apb_rr_master_arbiter
// PURPOSE
//  Shares one APB master port between NUM_REQ requesters (e.g. debug bridge, DMA, boot loader, core
//  side-band) using round-robin arbitration. Accepts one request at a time via valid/ready, runs a
//  full APB setup/access sequence on the shared port, and returns a one-cycle response to the
//  granted requester. A watchdog ends transfers whose slave never asserts pready.
// PARAMETERS
//  NUM_REQ        4    number of requesters (>=2)
//  ADDR_WIDTH     32   APB address width
//  DATA_WIDTH     32   APB data width (multiple of 8)
//  TIMEOUT_CYCLES 256  max ACCESS cycles before forced error completion; 0 disables timeout
// PORTS
//  clk_i        in   1                      clock, all logic on rising edge
//  rst_ni       in   1                      synchronous reset, active-low
//  req_valid_i  in   NUM_REQ                per-requester request valid
//  req_ready_o  out  NUM_REQ                per-requester accept (one-hot or zero)
//  req_write_i  in   NUM_REQ                1=write, 0=read
//  req_addr_i   in   NUM_REQ*ADDR_WIDTH     packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata_i  in   NUM_REQ*DATA_WIDTH     packed write data
//  req_strb_i   in   NUM_REQ*DATA_WIDTH/8   packed byte strobes (reads: driven as 0 on APB)
//  rsp_valid_o  out  NUM_REQ                one-cycle response pulse to the owning requester
//  rsp_rdata_o  out  DATA_WIDTH             read data, valid with rsp_valid_o (0 for writes/timeouts)
//  rsp_err_o    out  1                      pslverr or timeout, valid with rsp_valid_o
//  psel_o, penable_o, pwrite_o  out  1      APB controls
//  paddr_o      out  ADDR_WIDTH             APB address
//  pwdata_o     out  DATA_WIDTH             APB write data
//  pstrb_o      out  DATA_WIDTH/8           APB byte strobes
//  pready_i, pslverr_i  in  1               APB slave response
//  prdata_i     in   DATA_WIDTH             APB read data
// BEHAVIOUR
//  Reset (rst_ni=0 at edge): state IDLE; all outputs 0; RR pointer = NUM_REQ-1 (req 0 highest first).
//  FSM: IDLE -> SETUP -> ACCESS -> IDLE.
//  IDLE: if any req_valid_i, winner = first set bit searching from pointer+1 (mod NUM_REQ);
//   req_ready_o[winner]=1 combinationally this cycle; at the edge latch write/addr/wdata/strb and
//   owner, set pointer=winner, go SETUP. No valid: stay IDLE, all req_ready_o=0.
//  SETUP: psel_o=1, penable_o=0, paddr/pwrite/pwdata/pstrb from latched request; 1 cycle -> ACCESS.
//  ACCESS: psel_o=1, penable_o=1, APB fields held stable. Cycle with pready_i=1: at the edge capture
//   prdata_i (reads only, else 0) and pslverr_i, go IDLE, next cycle rsp_valid_o[owner]=1.
//   Timeout: if TIMEOUT_CYCLES!=0 and pready_i stays 0 for TIMEOUT_CYCLES ACCESS cycles, complete at
//   that edge with rsp_err_o=1, rsp_rdata_o=0; psel_o/penable_o drop.
//  psel_o/penable_o are 0 in IDLE, including the response cycle; paddr_o etc. hold the last value.
//  Response: rsp_valid_o is a registered one-cycle pulse, no backpressure; rsp_rdata_o/rsp_err_o are
//   valid only with it. A new request may be accepted in the same cycle as the response pulse.
//  Latency (pready tied 1): accept c0, SETUP c1, ACCESS c2, rsp_valid c3; each wait state adds 1.
//   Back-to-back throughput: one transfer per 3 cycles.
//  Requester rules: once req_valid_i[i]=1 it holds valid and fields until req_ready_o[i]; unchecked.
//   The latched copy isolates the APB bus from requester changes after acceptance.
//  Reset mid-transfer: next edge IDLE, psel/penable 0, no response pulse, pointer reinitialised.
//  Watchdog counter is ceil(log2(TIMEOUT_CYCLES+1)) bits, cleared on entry to ACCESS; no wrap.
// TESTING
//  1 req0 write addr 0x10 data 0xDEADBEEF strb 0xF, pready=1 -> psel c1, penable c2,
//    pwdata=0xDEADBEEF, rsp_valid_o=4'b0001 at c3, rsp_err_o=0.
//  2 req1 read 0x20, pready low 3 cycles then high with prdata 0x12345678 -> penable high 4 cycles,
//    pstrb_o=0, rsp_valid_o=4'b0010, rsp_rdata_o=0x12345678.
//  3 All 4 requesters valid continuously -> grant order 0,1,2,3,0,1; exactly one req_ready_o per
//    accept; transfers start every 3 cycles.
//  4 req2 write, pslverr_i=1 with pready -> rsp_valid_o=4'b0100, rsp_err_o=1, rsp_rdata_o=0.
//  5 TIMEOUT_CYCLES=8, pready held 0 -> after 8 ACCESS cycles psel drops, rsp_err_o=1, rdata=0;
//    next queued request then proceeds normally.
//  6 rst_ni=0 for one cycle during ACCESS -> next cycle psel=penable=0, no rsp_valid_o; with all
//    valid, first grant afterwards goes to req0.

Source files
------------

// File: rtl/apb_rr_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_master_arbiter
//
// Shares one APB master port between NUM_REQ requesters using round-robin
// arbitration. One request is accepted at a time through valid/ready, copied
// into a local register set, driven onto APB as a SETUP/ACCESS pair, and
// answered with a one-cycle response pulse to the requester that owned it.
// A watchdog forces an error completion when the slave never asserts pready.
//
// state  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | bus released; arbitrate and accept at most one request per cycle
// SETUP  | psel=1, penable=0, latched request on the APB fields
// ACCESS | psel=1, penable=1, wait for pready or watchdog expiry
//
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   req_valid_i / req_ready_o  per-requester handshake (ready one-hot or zero)
//   req_write_i                per-requester direction, 1 = write
//   req_addr_i/wdata_i/strb_i  packed request fields, requester i at slice i
//   rsp_valid_o                one-cycle response pulse to the owner
//   rsp_rdata_o, rsp_err_o     response payload, valid with rsp_valid_o
//   psel_o ... pstrb_o         APB master outputs
//   pready_i, pslverr_i,
//   prdata_i                   APB slave response
// -----------------------------------------------------------------------------
module apb_rr_master_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,

    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [NUM_REQ-1:0]               req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_strb_i,

    output logic [NUM_REQ-1:0]               rsp_valid_o,
    output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
    output logic                             rsp_err_o,

    output logic                             psel_o,
    output logic                             penable_o,
    output logic                             pwrite_o,
    output logic [ADDR_WIDTH-1:0]            paddr_o,
    output logic [DATA_WIDTH-1:0]            pwdata_o,
    output logic [DATA_WIDTH/8-1:0]          pstrb_o,
    input  logic                             pready_i,
    input  logic                             pslverr_i,
    input  logic [DATA_WIDTH-1:0]            prdata_i
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // Counter value seen during the last allowed ACCESS cycle: the counter is
    // cleared on entry, so the N-th ACCESS cycle observes N-1.
    localparam logic [WDOG_W-1:0] WDOG_LAST =
        WDOG_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                 state_q,     state_d;
    logic [IDX_W-1:0]       ptr_q,       ptr_d;
    logic [IDX_W-1:0]       owner_q,     owner_d;
    logic                   write_q,     write_d;
    logic [ADDR_WIDTH-1:0]  addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q,     wdata_d;
    logic [STRB_W-1:0]      strb_q,      strb_d;
    logic [WDOG_W-1:0]      wdog_q,      wdog_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q,   rsp_err_d;

    logic                   grant_any;
    logic [IDX_W-1:0]       grant_idx;

    // (base + off) mod NUM_REQ for off in 1..NUM_REQ; one subtraction suffices
    // because the sum never reaches 2*NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Round-robin pick: the first valid requester after the last winner.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr_q;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!grant_any && req_valid_i[rr_idx(ptr_q, i)]) begin
                grant_any = 1'b1;
                grant_idx = rr_idx(ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        wdog_d      = wdog_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        req_ready_o = '0;

        case (state_q)
            ST_IDLE: begin
                // Ready is withheld while reset is asserted: the reset edge
                // would discard the request, so accepting it would be a lie.
                if (grant_any && rst_ni) begin
                    req_ready_o[grant_idx] = 1'b1;
                    owner_d = grant_idx;
                    ptr_d   = grant_idx;
                    write_d = req_write_i[grant_idx];
                    addr_d  = req_addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    strb_d  = req_write_i[grant_idx] ?
                              req_strb_i[grant_idx*STRB_W +: STRB_W] : '0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                wdog_d  = '0;
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (pready_i) begin
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_rdata_d = write_q ? '0 : prdata_i;
                    rsp_err_d   = pslverr_i;
                    state_d     = ST_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (wdog_q == WDOG_LAST)) begin
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            wdog_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            wdog_q      <= wdog_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign psel_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable_o   = (state_q == ST_ACCESS);
    assign pwrite_o    = write_q;
    assign paddr_o     = addr_q;
    assign pwdata_o    = wdata_q;
    assign pstrb_o     = strb_q;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_rr_master_arbiter
//
// Directed bench for apb_rr_master_arbiter (4 requesters, 32-bit APB, watchdog
// of 8 ACCESS cycles). Inputs change 1 time unit after the rising edge and
// outputs are sampled in the same window, away from the active edge.
// -----------------------------------------------------------------------------
module tb_apb_rr_master_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;

    logic                 clk_sys;
    logic                 rst_ni;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_write;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*SW-1:0]   req_strb;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [AW-1:0]        paddr;
    logic [DW-1:0]        pwdata;
    logic [SW-1:0]        pstrb;
    logic                 pready;
    logic                 pslverr;
    logic [DW-1:0]        prdata;

    int n_checks;
    int n_errors;

    apb_rr_master_arbiter #(
        .NUM_REQ        (NREQ),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk_i       (clk_sys),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_strb_i  (req_strb),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .paddr_o     (paddr),
        .pwdata_o    (pwdata),
        .pstrb_o     (pstrb),
        .pready_i    (pready),
        .pslverr_i   (pslverr),
        .prdata_i    (prdata)
    );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      int g;
      n_checks  = 0;
      n_errors  = 0;
      rst_ni    = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_strb  = '0;
      pready    = 1'b1;
      pslverr   = 1'b0;
      prdata    = '0;

      // reset state
      tick();
      tick();
      check_val("rst_psel",      32'(psel),      32'h0);
      check_val("rst_penable",   32'(penable),   32'h0);
      check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check_val("rst_paddr",     paddr,          32'h0);
      check_val("rst_ready",     32'(req_ready), 32'h0);
      rst_ni = 1'b1;
      tick();

      // req0 write, zero wait states
      req_write[0]       = 1'b1;
      req_addr[0*AW +: AW]  = 32'h10;
      req_wdata[0*DW +: DW] = 32'hDEADBEEF;
      req_strb[0*SW +: SW]  = 4'hF;
      req_valid          = 4'b0001;
      #1;
      check_val("t1_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      check_val("t1_setup_psel",    32'(psel),    32'h1);
      check_val("t1_setup_penable", 32'(penable), 32'h0);
      check_val("t1_paddr",         paddr,        32'h10);
      check_val("t1_pwrite",        32'(pwrite),  32'h1);
      tick();
      check_val("t1_acc_penable", 32'(penable), 32'h1);
      check_val("t1_pwdata",      pwdata,       32'hDEADBEEF);
      check_val("t1_pstrb",       32'(pstrb),   32'hF);
      check_val("t1_no_rsp_yet",  32'(rsp_valid), 32'h0);
      tick();
      check_val("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      check_val("t1_rsp_err",   32'(rsp_err),   32'h0);
      check_val("t1_rsp_psel",  32'(psel),      32'h0);
      tick();
      check_val("t1_rsp_pulse_end", 32'(rsp_valid), 32'h0);

      // req1 read with three wait states
      req_write[1]          = 1'b0;
      req_addr[1*AW +: AW]  = 32'h20;
      req_strb[1*SW +: SW]  = 4'hF;
      req_valid             = 4'b0010;
      #1;
      check_val("t2_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      pready    = 1'b0;
      check_val("t2_pstrb",  32'(pstrb),  32'h0);
      check_val("t2_pwrite", 32'(pwrite), 32'h0);
      check_val("t2_paddr",  paddr,       32'h20);
      tick();
      for (int k = 1; k <= 4; k++) begin
         pready = (k == 4);
         prdata = (k == 4) ? 32'h12345678 : 32'h0;
         check_val($sformatf("t2_penable_%0d", k), 32'(penable), 32'h1);
         tick();
      end
      check_val("t2_rsp_valid", 32'(rsp_valid), 32'h2);
      check_val("t2_rsp_rdata", rsp_rdata,       32'h12345678);
      check_val("t2_rsp_err",   32'(rsp_err),    32'h0);
      pready = 1'b1;
      prdata = '0;

      // reset pointer, then all four requesters valid continuously
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         req_write[i]          = 1'b0;
         req_addr[i*AW +: AW]  = 32'h100 * (i + 1);
         req_strb[i*SW +: SW]  = 4'h0;
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         g = k % 4;
         #1;
         check_val($sformatf("t3_grant_%0d", k), 32'(req_ready), 32'(1 << g));
         tick();
         check_val($sformatf("t3_setup_ready_%0d", k), 32'(req_ready), 32'h0);
         check_val($sformatf("t3_setup_psel_%0d", k),  32'({psel, penable}), 32'h2);
         check_val($sformatf("t3_paddr_%0d", k), paddr, 32'(32'h100 * (g + 1)));
         tick();
         tick();
         check_val($sformatf("t3_rsp_%0d", k), 32'(rsp_valid), 32'(1 << g));
      end
      req_valid = '0;
      tick();

      // req2 write answered with pslverr
      req_write[2]          = 1'b1;
      req_addr[2*AW +: AW]  = 32'h40;
      req_wdata[2*DW +: DW] = 32'hCAFEF00D;
      req_strb[2*SW +: SW]  = 4'h3;
      req_valid             = 4'b0100;
      pslverr               = 1'b1;
      prdata                = 32'hFFFFFFFF;
      #1;
      check_val("t4_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      check_val("t4_pstrb", 32'(pstrb), 32'h3);
      tick();
      tick();
      check_val("t4_rsp_valid", 32'(rsp_valid), 32'h4);
      check_val("t4_rsp_err",   32'(rsp_err),   32'h1);
      check_val("t4_rsp_rdata", rsp_rdata,      32'h0);
      pslverr = 1'b0;
      prdata  = '0;
      tick();

      // req3 read times out after 8 ACCESS cycles, req0 queued behind it
      req_write[3]         = 1'b0;
      req_addr[3*AW +: AW] = 32'h30;
      req_valid            = 4'b1000;
      #1;
      check_val("t5_ready", 32'(req_ready), 32'h8);
      tick();
      req_write[0]         = 1'b0;
      req_addr[0*AW +: AW] = 32'h50;
      req_valid            = 4'b0001;
      pready               = 1'b0;
      prdata               = 32'hA5A5A5A5;
      #1;
      check_val("t5_setup_ready", 32'(req_ready), 32'h0);
      tick();
      for (int k = 1; k <= 8; k++) begin
         check_val($sformatf("t5_penable_%0d", k), 32'(penable), 32'h1);
         tick();
      end
      check_val("t5_to_psel",      32'(psel),      32'h0);
      check_val("t5_to_rsp_valid", 32'(rsp_valid), 32'h8);
      check_val("t5_to_rsp_err",   32'(rsp_err),   32'h1);
      check_val("t5_to_rsp_rdata", rsp_rdata,      32'h0);
      check_val("t5_queued_ready", 32'(req_ready), 32'h1);
      pready = 1'b1;
      tick();
      req_valid = '0;
      check_val("t5_q_paddr", paddr,       32'h50);
      check_val("t5_q_psel",  32'(psel),   32'h1);
      tick();
      tick();
      check_val("t5_q_rsp_valid", 32'(rsp_valid), 32'h1);
      check_val("t5_q_rsp_err",   32'(rsp_err),   32'h0);
      check_val("t5_q_rsp_rdata", rsp_rdata,      32'hA5A5A5A5);
      prdata = '0;

      // reset during ACCESS
      req_valid = 4'b0010;
      #1;
      check_val("t6_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      pready    = 1'b0;
      tick();
      check_val("t6_acc_penable", 32'(penable), 32'h1);
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      check_val("t6_psel",      32'(psel),      32'h0);
      check_val("t6_penable",   32'(penable),   32'h0);
      check_val("t6_rsp_valid", 32'(rsp_valid), 32'h0);
      pready    = 1'b1;
      req_valid = 4'b1111;
      #1;
      check_val("t6_first_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      check_val("t6_no_late_rsp", 32'(rsp_valid), 32'h0);
      tick();
      tick();
      check_val("t6_rsp_valid_after", 32'(rsp_valid), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
